// File: rtl/risc_control_sequencer.sv
// Multi-cycle control FSM for the KGP-RISC data path.
// Sequences fetch/decode/execute/memory/writeback with BRAM wait states.
module risc_control_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funccode,
    output logic [1:0]       reg_dest,
    output logic             reg_write,
    output logic [2:0]       ALUop,
    output logic [1:0]       ALUsource,
    output logic             mem_write,
    output logic [1:0]       mem_to_reg,
    output logic [2:0]       branch,
    output logic             pc_en,
    output logic             ir_en,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EXEC,
        S_MEM, S_MWAIT, S_WB, S_HALT
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [2:0]       aluop_q, aluop_d;
    logic [1:0]       src_q, src_d;
    logic [1:0]       rdest_q, rdest_d;
    logic [1:0]       m2r_q, m2r_d;
    logic [2:0]       br_q, br_d;
    logic             rw_q, rw_d;
    logic             mw_q, mw_d;
    logic             mem_q, mem_d;
    logic             wait_st, last, active;
    logic             unused_fc;

    assign unused_fc = ^funccode[5:4];
    assign wait_st   = (state_q == S_FWAIT) || (state_q == S_MWAIT);
    assign last      = (cnt_q == LAT_M1);
    // Decoded fields are only visible while the instruction owns the data path.
    assign active    = (state_q == S_EXEC) || (state_q == S_MEM) ||
                       (state_q == S_MWAIT) || (state_q == S_WB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retired_q <= '0;
            aluop_q   <= '0;
            src_q     <= '0;
            rdest_q   <= '0;
            m2r_q     <= '0;
            br_q      <= '0;
            rw_q      <= 1'b0;
            mw_q      <= 1'b0;
            mem_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
            aluop_q   <= aluop_d;
            src_q     <= src_d;
            rdest_q   <= rdest_d;
            m2r_q     <= m2r_d;
            br_q      <= br_d;
            rw_q      <= rw_d;
            mw_q      <= mw_d;
            mem_q     <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_FWAIT;
            S_FWAIT:  if (last) state_d = S_DECODE;
            S_DECODE: state_d = (opcode == 6'd63) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = mem_q ? S_MEM : S_WB;
            S_MEM:    state_d = S_MWAIT;
            S_MWAIT:  if (last) state_d = S_WB;
            S_WB:     state_d = run ? S_FETCH : S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (wait_st && !last) cnt_d = cnt_q + 2'd1;
        retired_d = retired_q;
        if (state_q == S_WB && retired_q != '1)
            retired_d = retired_q + 1'b1;
    end

    always_comb begin
        aluop_d = aluop_q;
        src_d   = src_q;
        rdest_d = rdest_q;
        m2r_d   = m2r_q;
        br_d    = br_q;
        rw_d    = rw_q;
        mw_d    = mw_q;
        mem_d   = mem_q;
        if (state_q == S_DECODE) begin
            aluop_d = '0;
            src_d   = '0;
            rdest_d = '0;
            m2r_d   = '0;
            br_d    = '0;
            rw_d    = 1'b0;
            mw_d    = 1'b0;
            mem_d   = 1'b0;
            case (opcode)
                6'd0: begin
                    aluop_d = funccode[2:0];
                    src_d   = funccode[3] ? 2'b10 : 2'b00;
                    rw_d    = 1'b1;
                end
                6'd1: begin
                    aluop_d = funccode[2:0];
                    src_d   = 2'b01;
                    rw_d    = 1'b1;
                end
                6'd2: begin
                    src_d   = 2'b01;
                    rdest_d = 2'b01;
                    m2r_d   = 2'b01;
                    rw_d    = 1'b1;
                    mem_d   = 1'b1;
                end
                6'd3: begin
                    src_d   = 2'b01;
                    mw_d    = 1'b1;
                    mem_d   = 1'b1;
                end
                6'd4: begin
                    br_d    = funccode[2:0];
                    aluop_d = 3'b001;
                end
                6'd5: begin
                    br_d    = 3'b111;
                    rdest_d = 2'b10;
                    m2r_d   = 2'b10;
                    rw_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ALUop      = active ? aluop_q : '0;
    assign ALUsource  = active ? src_q   : '0;
    assign reg_dest   = active ? rdest_q : '0;
    assign mem_to_reg = active ? m2r_q   : '0;
    assign branch     = active ? br_q    : '0;
    assign reg_write  = (state_q == S_WB) && rw_q;
    assign mem_write  = (state_q == S_MEM) && mw_q;
    assign pc_en      = (state_q == S_WB);
    assign ir_en      = (state_q == S_FWAIT) && last;
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted     = (state_q == S_HALT);
    assign illegal    = (state_q == S_DECODE) && (opcode > 6'd5) &&
                        (opcode != 6'd63);
    assign retired    = retired_q;

endmodule

// File: tb/tb_risc_control_sequencer.sv
// Directed bench for risc_control_sequencer (MEM_LAT=1).
// Table of single instructions plus reset/run/halt sequences.
module tb_risc_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funccode = '0;
    logic [1:0]  reg_dest;
    logic        reg_write;
    logic [2:0]  ALUop;
    logic [1:0]  ALUsource;
    logic        mem_write;
    logic [1:0]  mem_to_reg;
    logic [2:0]  branch;
    logic        pc_en;
    logic        ir_en;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;
    int exp_ret = 0;

    risc_control_sequencer #(.MEM_LAT(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run),
        .opcode(opcode), .funccode(funccode),
        .reg_dest(reg_dest), .reg_write(reg_write),
        .ALUop(ALUop), .ALUsource(ALUsource),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .branch(branch), .pc_en(pc_en), .ir_en(ir_en),
        .busy(busy), .halted(halted), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fc;
        int         len;
        logic [2:0] aluop;
        logic [1:0] src;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic [2:0] br;
        int         rw;
        int         mw;
        int         ill;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge one cycle after WB.
    task automatic exec_one(input vec_t v, input string tag);
        int k, rw_n, mw_n, ill_n, ir_idx, mw_idx, rw_bad, len;
        logic [2:0] br_ex, aluop_wb, br_wb;
        logic [1:0] src_wb, rd_wb, m2r_wb;
        logic got;
        rw_n = 0; mw_n = 0; ill_n = 0; rw_bad = 0;
        ir_idx = -1; mw_idx = -1; got = 1'b0;
        br_ex = '0; aluop_wb = '0; br_wb = '0;
        src_wb = '0; rd_wb = '0; m2r_wb = '0;
        opcode = v.op;
        funccode = v.fc;
        for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
        chk({tag, " start_busy"}, 32'(busy), 32'd1);
        for (k = 0; k < 20; k++) begin
            if (k == 0)
                chk({tag, " fetch_zero"},
                    32'({ALUop, branch, ALUsource, reg_dest, mem_to_reg}), 0);
            if (k == 3) br_ex = branch;
            if (ir_en) ir_idx = k;
            if (illegal) ill_n++;
            if (reg_write) rw_n++;
            if (reg_write && !pc_en) rw_bad++;
            if (mem_write) begin
                mw_n++;
                mw_idx = k;
            end
            if (pc_en) begin
                got = 1'b1;
                aluop_wb = ALUop; br_wb = branch; src_wb = ALUsource;
                rd_wb = reg_dest; m2r_wb = mem_to_reg;
                break;
            end
            @(negedge clk);
        end
        len = got ? k + 1 : 99;
        chk({tag, " len"}, 32'(len), 32'(v.len));
        chk({tag, " ir_idx"}, 32'(ir_idx), 32'd1);
        chk({tag, " rw_cnt"}, 32'(rw_n), 32'(v.rw));
        chk({tag, " rw_outside_wb"}, 32'(rw_bad), 32'd0);
        chk({tag, " mw_cnt"}, 32'(mw_n), 32'(v.mw));
        if (v.mw > 0) chk({tag, " mw_idx"}, 32'(mw_idx), 32'd4);
        chk({tag, " illegal"}, 32'(ill_n), 32'(v.ill));
        chk({tag, " ALUop"}, 32'(aluop_wb), 32'(v.aluop));
        chk({tag, " ALUsource"}, 32'(src_wb), 32'(v.src));
        chk({tag, " reg_dest"}, 32'(rd_wb), 32'(v.rd));
        chk({tag, " mem_to_reg"}, 32'(m2r_wb), 32'(v.m2r));
        chk({tag, " branch_wb"}, 32'(br_wb), 32'(v.br));
        chk({tag, " branch_exec"}, 32'(br_ex), 32'(v.br));
        @(negedge clk);
        exp_ret++;
        chk({tag, " retired"}, retired, 32'(exp_ret));
    endtask

    initial begin
        int k;
        logic seen_mw;
        //           op     fc    len alu    src    rd     m2r    br  rw mw il
        tbl[0] = '{6'd0, 6'h02, 5, 3'b010, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0, 0};
        tbl[1] = '{6'd0, 6'h0D, 5, 3'b101, 2'b10, 2'b00, 2'b00, 3'b000, 1, 0, 0};
        tbl[2] = '{6'd1, 6'h06, 5, 3'b110, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0, 0};
        tbl[3] = '{6'd2, 6'h07, 7, 3'b000, 2'b01, 2'b01, 2'b01, 3'b000, 1, 0, 0};
        tbl[4] = '{6'd3, 6'h3F, 7, 3'b000, 2'b01, 2'b00, 2'b00, 3'b000, 0, 1, 0};
        tbl[5] = '{6'd4, 6'h03, 5, 3'b001, 2'b00, 2'b00, 2'b00, 3'b011, 0, 0, 0};
        tbl[6] = '{6'd5, 6'h00, 5, 3'b000, 2'b00, 2'b10, 2'b10, 3'b111, 1, 0, 0};
        tbl[7] = '{6'd9, 6'h0F, 5, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1};

        rst = 1'b0;
        run = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst pc_en", 32'(pc_en), 0);
        chk("rst retired", retired, 0);
        chk("rst outs", 32'({reg_write, mem_write, ir_en, halted, illegal,
                             ALUop, branch}), 0);
        rst = 1'b1;
        chk("release pc_en", 32'(pc_en), 0);
        chk("release writes", 32'({reg_write, mem_write}), 0);

        for (int i = 0; i < 8; i++)
            exec_one(tbl[i], $sformatf("v%0d", i));

        // run dropped mid-instruction: finish it, then IDLE
        run = 1'b0;
        exec_one(tbl[0], "rundrop");
        chk("rundrop busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        chk("rundrop idle", 32'(busy), 0);
        chk("rundrop ret", retired, 32'(exp_ret));

        // reset during MEM of sw
        opcode = 6'd3;
        funccode = 6'd0;
        run = 1'b1;
        seen_mw = 1'b0;
        for (k = 0; k < 20 && !mem_write; k++) @(negedge clk);
        chk("swrst reached_mem", 32'(mem_write), 1);
        rst = 1'b0;
        #1;
        chk("swrst mw", 32'(mem_write), 0);
        chk("swrst busy", 32'(busy), 0);
        chk("swrst pc_en", 32'(pc_en), 0);
        chk("swrst ret", retired, 0);
        @(negedge clk);
        rst = 1'b1;
        chk("swrst rel", 32'({mem_write, reg_write, pc_en}), 0);
        exp_ret = 0;
        exec_one(tbl[4], "swrestart");

        // HALT is sticky; run toggling ignored
        opcode = 6'd63;
        for (k = 0; k < 20 && !halted; k++) @(negedge clk);
        chk("halt halted", 32'(halted), 1);
        chk("halt busy", 32'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            run = i[0];
            @(negedge clk);
            if (!halted || pc_en || busy || illegal) begin
                chk("halt sticky", 32'({halted, pc_en, busy, illegal}),
                    32'b1000);
            end
        end
        chk("halt stay", 32'(halted), 1);
        chk("halt ret", retired, 32'(exp_ret));
        rst = 1'b0;
        #1;
        chk("halt rst", 32'(halted), 0);
        chk("halt rst ret", retired, 0);
        @(negedge clk);
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
